// File: rtl/ifetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifetch_unit_if : fetch-stage bus (instruction RAM port + IF/ID handshake)  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface ifetch_unit_if #(
  parameter int PC_W  = 8,
  parameter int IW    = 16,
  parameter int CNT_W = 16
);
  logic [PC_W-1:0]  IADDR;
  logic [IW-1:0]    IDATA;
  logic [IW-1:0]    IR;
  logic [PC_W-1:0]  IR_PC;
  logic             IR_VALID;
  logic             IR_READY;
  logic             BR_TAKEN;
  logic [PC_W-1:0]  BR_TARGET;
  logic             HALTED;
  logic [CNT_W-1:0] FETCH_CNT;

  modport master (
    output IADDR, IR, IR_PC, IR_VALID, HALTED, FETCH_CNT,
    input  IDATA, IR_READY, BR_TAKEN, BR_TARGET
  );

  modport slave (
    input  IADDR, IR, IR_PC, IR_VALID, HALTED, FETCH_CNT,
    output IDATA, IR_READY, BR_TAKEN, BR_TARGET
  );
endinterface
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifetch_unit : PC, IF/ID register with valid/ready, branch redirect, halt   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ifetch_unit #(
  parameter int            PC_W      = 8,
  parameter int            IW        = 16,
  parameter int            CNT_W     = 16,
  parameter logic [IW-1:0] HALT_WORD = '0
) (
  input  logic         CLK,
  input  logic         RESET,
  ifetch_unit_if.master bus
);

  localparam logic [0:0]      c_FETCH = 1'b0;
  localparam logic [0:0]      c_HALT  = 1'b1;
  localparam logic [PC_W-1:0] c_EVEN  = {{(PC_W-1){1'b1}}, 1'b0};

  logic [0:0]       r_state;
  logic [PC_W-1:0]  r_pc;
  logic [IW-1:0]    r_ir;
  logic [PC_W-1:0]  r_ir_pc;
  logic             r_ir_valid;
  logic [CNT_W-1:0] r_fetch_cnt;
  logic             w_free;
  logic [PC_W-1:0]  w_br_pc;

  assign w_free  = !r_ir_valid || bus.IR_READY;
  assign w_br_pc = bus.BR_TARGET & c_EVEN;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= c_FETCH;
      r_pc        <= '0;
      r_ir        <= '0;
      r_ir_pc     <= '0;
      r_ir_valid  <= 1'b0;
      r_fetch_cnt <= '0;
    end else begin
      case (r_state)
        c_FETCH: begin
          // Redirect wins over a stall: the held instruction is on the wrong path.
          if (bus.BR_TAKEN) begin
            r_pc       <= w_br_pc;
            r_ir_valid <= 1'b0;
          end else if (w_free) begin
            if (bus.IDATA == HALT_WORD) begin
              r_state    <= c_HALT;
              r_ir_valid <= 1'b0;
            end else begin
              r_ir        <= bus.IDATA;
              r_ir_pc     <= r_pc;
              r_ir_valid  <= 1'b1;
              r_pc        <= r_pc + PC_W'(2);
              r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
            end
          end
        end
        c_HALT: begin
          // A branch older than the halt word may still resolve and restart fetch.
          if (bus.BR_TAKEN) begin
            r_pc    <= w_br_pc;
            r_state <= c_FETCH;
          end
        end
        default: r_state <= c_FETCH;
      endcase
    end
  end

  assign bus.IADDR     = r_pc;
  assign bus.IR        = r_ir;
  assign bus.IR_PC     = r_ir_pc;
  assign bus.IR_VALID  = r_ir_valid;
  assign bus.HALTED    = (r_state == c_HALT);
  assign bus.FETCH_CNT = r_fetch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ifetch_unit : scoreboard bench for ifetch_unit with a behavioural RAM   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ifetch_unit;
  localparam int PC_W  = 8;
  localparam int IW    = 16;
  // Narrow counter so the wrap is reachable within a short run.
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [IW-1:0]   ir;
    logic [PC_W-1:0] pc;
  } xfer_t;

  logic  CLK = 1'b0;
  logic  RESET = 1'b1;
  logic  [IW-1:0] mem [0:127];
  xfer_t sb_q[$];
  xfer_t sb_e;
  bit    sb_en = 1'b1;
  int    n_checks = 0;
  int    n_pass = 0;

  ifetch_unit_if #(.PC_W(PC_W), .IW(IW), .CNT_W(CNT_W)) bus ();

  ifetch_unit #(.PC_W(PC_W), .IW(IW), .CNT_W(CNT_W), .HALT_WORD(16'h0000)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  assign bus.IDATA = mem[bus.IADDR[PC_W-1:1]];

  // Every accepted transfer must match the next queued expectation.
  always @(negedge CLK) begin
    if (sb_en && !RESET && bus.IR_VALID && bus.IR_READY) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected: got IR=%h IR_PC=%h, required no transfer", bus.IR, bus.IR_PC);
      end else begin
        sb_e = sb_q.pop_front();
        if ({bus.IR, bus.IR_PC} !== sb_e)
          $display("FAIL sb_xfer: got IR=%h IR_PC=%h, required IR=%h IR_PC=%h", bus.IR, bus.IR_PC, sb_e.ir, sb_e.pc);
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    bus.IR_READY = 1'b0;
    bus.BR_TAKEN = 1'b0;
    bus.BR_TARGET = '0;
    sb_q.delete();
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.IADDR !== 8'h00) $display("FAIL rst_iaddr: got %h required %h", bus.IADDR, 8'h00); else n_pass++;
    n_checks++; if (bus.IR !== 16'h0000) $display("FAIL rst_ir: got %h required %h", bus.IR, 16'h0000); else n_pass++;
    n_checks++; if (bus.IR_PC !== 8'h00) $display("FAIL rst_ir_pc: got %h required %h", bus.IR_PC, 8'h00); else n_pass++;
    n_checks++; if (bus.IR_VALID !== 1'b0) $display("FAIL rst_valid: got %b required 0", bus.IR_VALID); else n_pass++;
    n_checks++; if (bus.HALTED !== 1'b0) $display("FAIL rst_halted: got %b required 0", bus.HALTED); else n_pass++;
    n_checks++; if (bus.FETCH_CNT !== 8'h00) $display("FAIL rst_cnt: got %h required %h", bus.FETCH_CNT, 8'h00); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.IR_READY = 1'b1;
    sb_q.push_back('{16'hF001, 8'h00});
    sb_q.push_back('{16'hF491, 8'h02});
    sb_q.push_back('{16'hFFF9, 8'h04});
    tick();
    n_checks++; if ({bus.IR, bus.IR_PC, bus.IADDR, bus.IR_VALID} !== {16'hF001, 8'h00, 8'h02, 1'b1})
      $display("FAIL b2b_first: got IR=%h IR_PC=%h IADDR=%h V=%b, required F001 00 02 1", bus.IR, bus.IR_PC, bus.IADDR, bus.IR_VALID);
    else n_pass++;
    tick();
    tick();
    n_checks++; if ({bus.IR, bus.IR_PC, bus.FETCH_CNT} !== {16'hFFF9, 8'h04, 8'h03})
      $display("FAIL b2b_third: got IR=%h IR_PC=%h CNT=%h, required FFF9 04 03", bus.IR, bus.IR_PC, bus.FETCH_CNT);
    else n_pass++;
    bus.IR_READY = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    bus.IR_READY = 1'b1;
    sb_q.push_back('{16'hF001, 8'h00});
    sb_q.push_back('{16'hF491, 8'h02});
    tick();
    tick();
    bus.IR_READY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if ({bus.IR, bus.IR_PC, bus.IADDR, bus.FETCH_CNT, bus.IR_VALID} !== {16'hF491, 8'h02, 8'h04, 8'h02, 1'b1})
        $display("FAIL stall_hold%0d: got IR=%h IR_PC=%h IADDR=%h CNT=%h V=%b, required F491 02 04 02 1",
                 k, bus.IR, bus.IR_PC, bus.IADDR, bus.FETCH_CNT, bus.IR_VALID);
      else n_pass++;
    end
    bus.IR_READY = 1'b1;
    tick();
    n_checks++; if ({bus.IR, bus.IR_PC} !== {16'hFFF9, 8'h04})
      $display("FAIL stall_release: got IR=%h IR_PC=%h, required FFF9 04", bus.IR, bus.IR_PC);
    else n_pass++;
  endtask

  // Continues from test_stall: IR=FFF9 valid, PC=0x06, count 3.
  task automatic test_branch();
    bus.IR_READY = 1'b0;
    bus.BR_TAKEN = 1'b1;
    bus.BR_TARGET = 8'h11;
    tick();
    n_checks++; if ({bus.IR_VALID, bus.IADDR, bus.FETCH_CNT} !== {1'b0, 8'h10, 8'h03})
      $display("FAIL br_flush: got V=%b IADDR=%h CNT=%h, required 0 10 03", bus.IR_VALID, bus.IADDR, bus.FETCH_CNT);
    else n_pass++;
    bus.BR_TAKEN = 1'b0;
    sb_q.push_back('{16'h2139, 8'h10});
    tick();
    n_checks++; if ({bus.IR, bus.IR_PC, bus.IR_VALID, bus.FETCH_CNT} !== {16'h2139, 8'h10, 1'b1, 8'h04})
      $display("FAIL br_target: got IR=%h IR_PC=%h V=%b CNT=%h, required 2139 10 1 04", bus.IR, bus.IR_PC, bus.IR_VALID, bus.FETCH_CNT);
    else n_pass++;
  endtask

  // Continues from test_branch: runs 0x12..0x36 into the halt word at 0x38.
  task automatic test_halt();
    int cyc;
    bus.IR_READY = 1'b1;
    for (int a = 8'h12; a <= 8'h36; a += 2)
      sb_q.push_back('{16'hA000 | 16'(a), 8'(a)});
    cyc = 0;
    while (!bus.HALTED && cyc < 40) begin
      tick();
      cyc++;
    end
    n_checks++; if (bus.HALTED !== 1'b1) $display("FAIL halt_reach: got HALTED=%b after %0d cycles, required 1", bus.HALTED, cyc); else n_pass++;
    n_checks++; if (sb_q.size() != 0) $display("FAIL halt_drain: got %0d pending, required 0", sb_q.size()); else n_pass++;
    for (int k = 0; k < 10; k++) begin
      n_checks++; if ({bus.HALTED, bus.IR_VALID, bus.IADDR, bus.FETCH_CNT} !== {1'b1, 1'b0, 8'h38, 8'd23})
        $display("FAIL halt_hold%0d: got H=%b V=%b IADDR=%h CNT=%0d, required 1 0 38 23",
                 k, bus.HALTED, bus.IR_VALID, bus.IADDR, bus.FETCH_CNT);
      else n_pass++;
      tick();
    end
    bus.BR_TAKEN = 1'b1;
    bus.BR_TARGET = 8'h10;
    tick();
    n_checks++; if ({bus.HALTED, bus.IADDR, bus.IR_VALID} !== {1'b0, 8'h10, 1'b0})
      $display("FAIL halt_exit: got H=%b IADDR=%h V=%b, required 0 10 0", bus.HALTED, bus.IADDR, bus.IR_VALID);
    else n_pass++;
    bus.BR_TAKEN = 1'b0;
    sb_q.push_back('{16'h2139, 8'h10});
    tick();
    n_checks++; if ({bus.IR, bus.IR_VALID, bus.FETCH_CNT} !== {16'h2139, 1'b1, 8'd24})
      $display("FAIL halt_refetch: got IR=%h V=%b CNT=%0d, required 2139 1 24", bus.IR, bus.IR_VALID, bus.FETCH_CNT);
    else n_pass++;
    bus.IR_READY = 1'b0;
  endtask

  task automatic test_redirect_ack();
    do_reset();
    bus.IR_READY = 1'b1;
    sb_q.push_back('{16'hF001, 8'h00});
    tick();
    bus.BR_TAKEN = 1'b1;
    bus.BR_TARGET = 8'h20;
    tick();
    n_checks++; if ({bus.IR_VALID, bus.IADDR, bus.FETCH_CNT} !== {1'b0, 8'h20, 8'h01})
      $display("FAIL ack_flush: got V=%b IADDR=%h CNT=%h, required 0 20 01", bus.IR_VALID, bus.IADDR, bus.FETCH_CNT);
    else n_pass++;
    bus.BR_TAKEN = 1'b0;
    sb_q.push_back('{16'hA020, 8'h20});
    tick();
    n_checks++; if ({bus.IR, bus.IR_PC} !== {16'hA020, 8'h20})
      $display("FAIL ack_target: got IR=%h IR_PC=%h, required A020 20", bus.IR, bus.IR_PC);
    else n_pass++;
    tick();
    bus.IR_READY = 1'b0;
    n_checks++; if (sb_q.size() != 0) $display("FAIL ack_drain: got %0d pending, required 0", sb_q.size()); else n_pass++;
  endtask

  task automatic test_wrap();
    int cyc;
    mem[28] = 16'hA038;
    do_reset();
    sb_en = 1'b0;
    bus.IR_READY = 1'b1;
    cyc = 0;
    while (!(bus.IADDR == 8'hFE && bus.FETCH_CNT == 8'hFF) && cyc < 600) begin
      tick();
      cyc++;
    end
    n_checks++; if (cyc !== 255) $display("FAIL wrap_reach: got %0d cycles, required 255", cyc); else n_pass++;
    tick();
    n_checks++; if ({bus.IR, bus.IR_PC, bus.IADDR, bus.FETCH_CNT} !== {16'hA0FE, 8'hFE, 8'h00, 8'h00})
      $display("FAIL wrap_edge: got IR=%h IR_PC=%h IADDR=%h CNT=%h, required A0FE FE 00 00",
               bus.IR, bus.IR_PC, bus.IADDR, bus.FETCH_CNT);
    else n_pass++;
    bus.IR_READY = 1'b0;
    mem[28] = 16'h0000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    sb_en = 1'b1;
    tick();
    tick();
    n_checks++; if ({bus.IR_VALID, bus.IR} !== {1'b1, 16'hF001})
      $display("FAIL mid_stall_pre: got V=%b IR=%h, required 1 F001", bus.IR_VALID, bus.IR);
    else n_pass++;
    RESET = 1'b1;
    tick();
    n_checks++; if ({bus.IR, bus.IR_PC, bus.IR_VALID, bus.IADDR, bus.FETCH_CNT, bus.HALTED} !== {16'h0, 8'h0, 1'b0, 8'h0, 8'h0, 1'b0})
      $display("FAIL mid_stall_rst: got IR=%h IR_PC=%h V=%b IADDR=%h CNT=%h H=%b, required all zero",
               bus.IR, bus.IR_PC, bus.IR_VALID, bus.IADDR, bus.FETCH_CNT, bus.HALTED);
    else n_pass++;
    RESET = 1'b0;
    bus.BR_TAKEN = 1'b1;
    bus.BR_TARGET = 8'h38;
    tick();
    bus.BR_TAKEN = 1'b0;
    tick();
    n_checks++; if (bus.HALTED !== 1'b1) $display("FAIL mid_halt_pre: got H=%b, required 1", bus.HALTED); else n_pass++;
    RESET = 1'b1;
    tick();
    n_checks++; if ({bus.HALTED, bus.IADDR, bus.IR_VALID, bus.FETCH_CNT} !== {1'b0, 8'h00, 1'b0, 8'h00})
      $display("FAIL mid_halt_rst: got H=%b IADDR=%h V=%b CNT=%h, required 0 00 0 00", bus.HALTED, bus.IADDR, bus.IR_VALID, bus.FETCH_CNT);
    else n_pass++;
    RESET = 1'b0;
    bus.IR_READY = 1'b1;
    sb_q.push_back('{16'hF001, 8'h00});
    tick();
    n_checks++; if ({bus.IR, bus.IR_PC, bus.IR_VALID} !== {16'hF001, 8'h00, 1'b1})
      $display("FAIL mid_restart: got IR=%h IR_PC=%h V=%b, required F001 00 1", bus.IR, bus.IR_PC, bus.IR_VALID);
    else n_pass++;
    bus.IR_READY = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'hA000 | 16'(i * 2);
    mem[0]  = 16'hF001;
    mem[1]  = 16'hF491;
    mem[2]  = 16'hFFF9;
    mem[8]  = 16'h2139;
    mem[28] = 16'h0000;
    bus.IR_READY = 1'b0;
    bus.BR_TAKEN = 1'b0;
    bus.BR_TARGET = '0;

    test_reset();
    test_back_to_back();
    test_stall();
    test_branch();
    test_halt();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
